// File: rtl/btn_pkg.sv
// Shared constants and width helper for the button conditioning front end.
package btn_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int REPEAT_CYCLES_DEF   = 25000000;
    localparam int NUM_CHAN            = 2;

    // Smallest width w (at least 1) with 2**w >= n.
    function automatic int btn_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One button channel: two-flop synchroniser, stability counter, stable level and rise qualify.
module debounce_chan
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = btn_w(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_qualify;

    assign w_qualify = (r_s2 != r_stable) && (r_cnt >= CNT_MAX);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            // Any return to the stable value throws the partial count away.
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (w_qualify) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_stable;
    assign o_rise  = w_qualify && r_s2;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Two-button debounce with registered press pulses; btn0 wins simultaneous pulses.
// Auto-repeat of held buttons is built only when BTN_REPEAT_EN is defined.
module btn_debounce_pulse
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
`ifdef BTN_REPEAT_EN
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
`endif
    parameter int CNT_W           = btn_w(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic RST_BTN,
    input  logic btn0_raw,
    input  logic btn1_raw,
    output logic btn0,
    output logic btn1,
    output logic btn0_level,
    output logic btn1_level
);

    logic [NUM_CHAN-1:0] w_raw;
    logic [NUM_CHAN-1:0] w_level;
    logic [NUM_CHAN-1:0] w_rise;
    logic [NUM_CHAN-1:0] w_req;
    logic [NUM_CHAN-1:0] r_pulse;

    assign w_raw = {btn1_raw, btn0_raw};

    for (genvar g = 0; g < NUM_CHAN; g++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk     (clk),
            .i_rst   (RST_BTN),
            .i_raw   (w_raw[g]),
            .o_level (w_level[g]),
            .o_rise  (w_rise[g])
        );
    end

`ifdef BTN_REPEAT_EN
    localparam int               RPT_W   = btn_w(REPEAT_CYCLES);
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0]    r_rcnt [NUM_CHAN];
    logic [NUM_CHAN-1:0] w_fire;

    // Counter starts at 0 on the press edge, so the first repeat lands REPEAT_CYCLES later.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (RST_BTN || !w_level[i] || (r_rcnt[i] == RPT_MAX)) begin
                r_rcnt[i] <= '0;
            end else begin
                r_rcnt[i] <= r_rcnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        w_fire = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            w_fire[i] = w_level[i] && (r_rcnt[i] == RPT_MAX);
        end
    end

    assign w_req = w_rise | w_fire;
`else
    assign w_req = w_rise;
`endif

    always_ff @(posedge clk) begin
        if (RST_BTN) begin
            r_pulse <= '0;
        end else begin
            r_pulse[0] <= w_req[0];
            r_pulse[1] <= w_req[1] & ~w_req[0];
        end
    end

    assign btn0       = r_pulse[0];
    assign btn1       = r_pulse[1];
    assign btn0_level = w_level[0];
    assign btn1_level = w_level[1];

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with DEBOUNCE_CYCLES=8; pulse cycles are scoreboarded.
module tb_btn_debounce_pulse;

    localparam int D   = 8;
    localparam int LAT = D + 2;

    logic clk = 1'b0;
    logic RST_BTN;
    logic btn0_raw, btn1_raw;
    logic btn0, btn1, btn0_level, btn1_level;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int q0[$];
    int q1[$];

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES (D),
`ifdef BTN_REPEAT_EN
        .REPEAT_CYCLES   (16),
`endif
        .CNT_W           (4)
    ) dut (
        .clk        (clk),
        .RST_BTN    (RST_BTN),
        .btn0_raw   (btn0_raw),
        .btn1_raw   (btn1_raw),
        .btn0       (btn0),
        .btn1       (btn1),
        .btn0_level (btn0_level),
        .btn1_level (btn1_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d at cyc %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Pulse monitor: every observed pulse must match the next scheduled cycle.
    always @(negedge clk) begin
        int e;
        if (btn0 === 1'b1) begin
            e = (q0.size() != 0) ? q0.pop_front() : -1;
            check("btn0_pulse_cyc", cyc, e);
        end
        if (btn1 === 1'b1) begin
            e = (q1.size() != 0) ? q1.pop_front() : -1;
            check("btn1_pulse_cyc", cyc, e);
        end
        if (RST_BTN === 1'b0) check("never_both", int'(btn0 & btn1), 0);
    end

    task automatic drained(input string tag);
        check({tag, "_q0_empty"}, q0.size(), 0);
        check({tag, "_q1_empty"}, q1.size(), 0);
    endtask

    initial begin
        int c;
        RST_BTN  = 1'b1;
        btn0_raw = 1'b1;
        btn1_raw = 1'b1;

        // Reset hold with both buttons pressed.
        repeat (3) begin
            @(negedge clk);
            check("rst_outs", int'({btn0, btn1, btn0_level, btn1_level}), 0);
        end
        RST_BTN = 1'b0;
        c = cyc;
        q0.push_back(c + LAT);
        wait_to(c + LAT - 1);
        check("rst_lvl0_before", int'(btn0_level), 0);
        check("rst_lvl1_before", int'(btn1_level), 0);
        tick(1);
        check("rst_lvl0_after", int'(btn0_level), 1);
        check("rst_lvl1_after", int'(btn1_level), 1);
        btn0_raw = 1'b0;
        btn1_raw = 1'b0;
        tick(LAT + 2);
        check("rst_rel_lvl", int'({btn0_level, btn1_level}), 0);
        drained("rst");

        // Clean press on btn0, then release.
        c = cyc;
        btn0_raw = 1'b1;
        q0.push_back(c + LAT);
        wait_to(c + LAT - 1);
        check("clean_lvl_before", int'(btn0_level), 0);
        tick(1);
        check("clean_lvl_after", int'(btn0_level), 1);
        wait_to(c + 20);
        c = cyc;
        btn0_raw = 1'b0;
        wait_to(c + LAT - 1);
        check("rel_lvl_before", int'(btn0_level), 1);
        tick(1);
        check("rel_lvl_after", int'(btn0_level), 0);
        tick(5);
        drained("clean");

        // Bounce on btn1: toggles every 3 cycles, then held.
        for (int i = 0; i < 10; i++) begin
            btn1_raw = (i % 2 == 0);
            tick(3);
            check("bounce_lvl", int'(btn1_level), 0);
        end
        c = cyc;
        btn1_raw = 1'b1;
        q1.push_back(c + LAT);
        wait_to(c + LAT + 3);
        check("bounce_lvl_final", int'(btn1_level), 1);
        btn1_raw = 1'b0;
        tick(LAT + 2);
        drained("bounce");

        // Seven-cycle glitch on btn0 never qualifies.
        btn0_raw = 1'b1;
        tick(7);
        btn0_raw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            check("glitch_lvl", int'(btn0_level), 0);
        end

        // Eight-cycle pulse is the shortest that qualifies.
        c = cyc;
        btn0_raw = 1'b1;
        q0.push_back(c + LAT);
        tick(8);
        btn0_raw = 1'b0;
        wait_to(c + LAT);
        check("min_press_lvl", int'(btn0_level), 1);
        tick(LAT + 2);
        check("min_press_rel", int'(btn0_level), 0);
        drained("glitch");

        // Simultaneous press: btn1 pulse dropped, both levels rise together.
        c = cyc;
        btn0_raw = 1'b1;
        btn1_raw = 1'b1;
        q0.push_back(c + LAT);
        wait_to(c + LAT - 1);
        check("simul_lvl_before", int'({btn0_level, btn1_level}), 0);
        tick(1);
        check("simul_lvl_after", int'({btn0_level, btn1_level}), 3);
        btn0_raw = 1'b0;
        btn1_raw = 1'b0;
        tick(LAT + 2);
        drained("simul");

        // Reset mid-count discards the partial count.
        btn1_raw = 1'b1;
        tick(6);
        RST_BTN = 1'b1;
        tick(1);
        RST_BTN = 1'b0;
        c = cyc;
        q1.push_back(c + LAT);
        wait_to(c + LAT - 1);
        check("midrst_lvl_before", int'(btn1_level), 0);
        tick(1);
        check("midrst_lvl_after", int'(btn1_level), 1);
        btn1_raw = 1'b0;
        tick(LAT + 2);
        drained("midrst");

`ifdef BTN_REPEAT_EN
        // Held button repeats every 16 cycles after the press pulse.
        c = cyc;
        btn0_raw = 1'b1;
        for (int k = 0; k < 4; k++) q0.push_back(c + LAT + 16 * k);
        wait_to(c + 60);
        btn0_raw = 1'b0;
        tick(40);
        check("rpt_rel_lvl", int'(btn0_level), 0);
        drained("repeat");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
